alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
- Registered result/flag stage directly downstream of the 32-bit subtractor and adder.
- Captures the raw sum/difference and carry-out, computes N/Z/C/V flags, and holds them in a 2-entry skid buffer.
- Uses a valid/ready handshake toward the writeback consumer, so subtractor outputs are never lost under back-pressure.

Parameters:
- N, 32, datapath width; must match the adder/subtractor width.
- DEPTH, 2, skid-buffer entries; fixed at 2, any other value is a compile-time error.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream result valid this cycle.
- in_ready  output  1  stage can accept a result.
- in_sub  input  1  1 = result came from subtract, 0 = add.
- in_a_msb  input  1  operand A bit N-1.
- in_b_msb  input  1  operand B bit N-1, as presented to the block before inversion.
- in_res  input  N  raw sum/difference.
- in_cout  input  1  raw carry-out from the adder/subtractor.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer accepts the head entry.
- out_res  output  N  registered result.
- out_flags  output  4  {N,Z,C,V}.
- occupancy  output  2  entries held (0..2).

Behaviour:
- Reset (asynchronous, rst_n=0):
  - out_valid=0, out_res=0, out_flags=0, occupancy=0, in_ready=1.
  - Both entries are invalidated immediately.
  - A transfer in flight during reset is dropped.
- Accept and release rules:
  - Input accepted when in_valid && in_ready at a rising clk edge.
  - Output released when out_valid && out_ready.
- Flags, computed combinationally from inputs and stored with the entry:
  - N = in_res[N-1].
  - Z = (in_res == 0).
  - C = in_cout, unmodified. For subtract, C=1 means no borrow.
  - V, add: (a_msb == b_msb) && (res_msb != a_msb).
  - V, subtract: (a_msb != b_msb) && (res_msb != a_msb).
- Latency: 1 cycle. An accepted input appears on out_* the next cycle when the buffer was empty.
- State machine, tracked by occupancy:
  - EMPTY:
    - accept → ONE.
    - otherwise stay.
  - ONE:
    - accept && release → ONE; new entry becomes head.
    - accept only → TWO.
    - release only → EMPTY.
  - TWO:
    - release → ONE; second entry moves to head.
    - accept is impossible.
- in_ready is registered: 1 in EMPTY and ONE, 0 in TWO. It is not a function of out_ready, so there is no combinational ready path.
- Ordering: strict FIFO. The head is never overwritten while out_valid && !out_ready.
- Output stability: out_res and out_flags hold stable while out_valid=1 and out_ready=0.
- Idle: in_valid=0 leaves the state unchanged.
- Z when N=32 and res=32'h0000_0000: Z=1, whatever the carry.

Optional Feature:
- Macro: ALU_STICKY_OVF_EN.
- With the macro defined:
  - Adds output sticky_v (1 bit), reset 0.
  - sticky_v sets on any accepted input whose V=1.
  - It clears only when input clr_sticky=1 (1 bit, synchronous).
  - If clear and set happen in the same cycle, set wins.
  - Also adds a 16-bit saturating counter ovf_count of accepted V=1 results, reset 0, cleared by clr_sticky.
- Without the macro: these ports and registers do not exist. Behaviour is otherwise identical.

Decomposition:
- Shared package alu_pkg holds:
  - constant ALU_W=32.
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - 2-bit occupancy state encoding OCC_EMPTY=0, OCC_ONE=1, OCC_TWO=2.
- One sub-module, alu_flag_gen: combinational N/Z/C/V from res/cout/msbs/sub. It is reusable by the adder path.
- The skid buffer stays inline.

Test Plan:
- Subtract 5−3: in_res=32'h2, cout=1, a_msb=0, b_msb=0, sub=1 → next cycle out_res=2, flags N0 Z0 C1 V0, occupancy=1.
- Subtract 0x80000000−1: res=0x7FFFFFFF, a_msb=1, b_msb=0, sub=1 → V=1, N=0; with ALU_STICKY_OVF_EN, sticky_v=1 and ovf_count=1.
- Back-pressure: out_ready=0, push results 7 then 9 → occupancy=2, in_ready=0 the following cycle, out_res holds 7. Raise out_ready → 7 then 9 emitted in order, in_ready returns to 1.
- Simultaneous push/pop in ONE: head=7, push 9 with out_ready=1 → occupancy stays 1, out_res=9 next cycle, no entry lost.
- Zero result: add 0xFFFFFFFF+1, res=0, cout=1, sub=0 → Z=1, C=1, V=0, N=0.
- Reset mid-operation: occupancy=2, drop rst_n asynchronously between edges → out_valid=0, occupancy=0, in_ready=1 before the next clk edge; after release, first accepted input emerges with 1-cycle latency.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU constants: datapath width, flag bit positions and skid-buffer occupancy encoding.
package alu_pkg;

   localparam int unsigned ALU_W  = 32;

   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational N/Z/C/V flag generation for an add/subtract result; shared by adder and subtractor paths.
module alu_flag_gen
   import alu_pkg::*;
#(
   parameter int unsigned N = ALU_W
) (
   input  logic         i_sub,
   input  logic         i_a_msb,
   input  logic         i_b_msb,
   input  logic [N-1:0] i_res,
   input  logic         i_cout,
   output logic [3:0]   o_flags
);

   logic w_res_msb;
   logic w_ovf;

   assign w_res_msb = i_res[N-1];

   // b_msb is the operand before inversion, so subtract overflows when the operand signs differ
   always_comb begin
      w_ovf = 1'b0;
      if (i_sub) w_ovf = (i_a_msb != i_b_msb) && (w_res_msb != i_a_msb);
      else       w_ovf = (i_a_msb == i_b_msb) && (w_res_msb != i_a_msb);
   end

   always_comb begin
      o_flags         = '0;
      o_flags[FLAG_N] = w_res_msb;
      o_flags[FLAG_Z] = (i_res == '0);
      o_flags[FLAG_C] = i_cout;
      o_flags[FLAG_V] = w_ovf;
   end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result/flag stage with a 2-entry skid buffer and valid/ready handshake.
// Optional sticky overflow flag and saturating overflow counter under `ALU_STICKY_OVF_EN.
module alu_result_stage
   import alu_pkg::*;
#(
   parameter int unsigned N     = ALU_W,
   parameter int unsigned DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         in_sub,
   input  logic         in_a_msb,
   input  logic         in_b_msb,
   input  logic [N-1:0] in_res,
   input  logic         in_cout,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_res,
   output logic [3:0]   out_flags,
   output logic [1:0]   occupancy
`ifdef ALU_STICKY_OVF_EN
   ,
   input  logic         clr_sticky,
   output logic         sticky_v,
   output logic [15:0]  ovf_count
`endif
);

   generate
      if (DEPTH != 2) begin : g_depth_check
         $error("alu_result_stage: DEPTH must be 2");
      end
   endgenerate

   occ_t         r_occ;
   logic         r_in_ready;
   logic         r_out_valid;
   logic [N-1:0] r_head_res;
   logic [3:0]   r_head_flags;
   logic [N-1:0] r_tail_res;
   logic [3:0]   r_tail_flags;

   logic [3:0]   w_flags;
   logic         w_acc;
   logic         w_rel;

   alu_flag_gen #(.N(N)) u_flag_gen (
      .i_sub   (in_sub),
      .i_a_msb (in_a_msb),
      .i_b_msb (in_b_msb),
      .i_res   (in_res),
      .i_cout  (in_cout),
      .o_flags (w_flags)
   );

   assign w_acc = in_valid && r_in_ready;
   assign w_rel = r_out_valid && out_ready;

   // Head is rewritten only when it is released in the same cycle, so it stays stable under back-pressure
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_occ        <= OCC_EMPTY;
         r_in_ready   <= 1'b1;
         r_out_valid  <= 1'b0;
         r_head_res   <= '0;
         r_head_flags <= '0;
         r_tail_res   <= '0;
         r_tail_flags <= '0;
      end else begin
         case (r_occ)
            OCC_EMPTY: begin
               if (w_acc) begin
                  r_head_res   <= in_res;
                  r_head_flags <= w_flags;
                  r_occ        <= OCC_ONE;
                  r_out_valid  <= 1'b1;
               end
            end
            OCC_ONE: begin
               if (w_acc && w_rel) begin
                  r_head_res   <= in_res;
                  r_head_flags <= w_flags;
               end else if (w_acc) begin
                  r_tail_res   <= in_res;
                  r_tail_flags <= w_flags;
                  r_occ        <= OCC_TWO;
                  r_in_ready   <= 1'b0;
               end else if (w_rel) begin
                  r_occ        <= OCC_EMPTY;
                  r_out_valid  <= 1'b0;
               end
            end
            OCC_TWO: begin
               if (w_rel) begin
                  r_head_res   <= r_tail_res;
                  r_head_flags <= r_tail_flags;
                  r_occ        <= OCC_ONE;
                  r_in_ready   <= 1'b1;
               end
            end
            default: begin
               r_occ       <= OCC_EMPTY;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_res   = r_head_res;
   assign out_flags = r_head_flags;
   assign occupancy = r_occ;

`ifdef ALU_STICKY_OVF_EN
   logic        r_sticky_v;
   logic [15:0] r_ovf_count;
   logic        w_set;

   assign w_set = w_acc && w_flags[FLAG_V];

   // A set in the same cycle as a clear wins: sticky stays 1 and the count restarts at 1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sticky_v  <= 1'b0;
         r_ovf_count <= '0;
      end else if (w_set) begin
         r_sticky_v  <= 1'b1;
         if (clr_sticky)              r_ovf_count <= 16'd1;
         else if (r_ovf_count != '1)  r_ovf_count <= r_ovf_count + 16'd1;
      end else if (clr_sticky) begin
         r_sticky_v  <= 1'b0;
         r_ovf_count <= '0;
      end
   end

   assign sticky_v  = r_sticky_v;
   assign ovf_count = r_ovf_count;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed vector table, hand-written handshake/reset sequences,
// then randomized traffic against an arithmetic reference model with a FIFO scoreboard.
module tb_alu_result_stage;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        in_sub;
   logic        in_a_msb;
   logic        in_b_msb;
   logic [31:0] in_res;
   logic        in_cout;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_res;
   logic [3:0]  out_flags;
   logic [1:0]  occupancy;
`ifdef ALU_STICKY_OVF_EN
   logic        clr_sticky;
   logic        sticky_v;
   logic [15:0] ovf_count;
`endif

   int unsigned errors = 0;
   int unsigned checks = 0;

   always #5 clk = ~clk;

   alu_result_stage #(.N(32), .DEPTH(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sub    (in_sub),
      .in_a_msb  (in_a_msb),
      .in_b_msb  (in_b_msb),
      .in_res    (in_res),
      .in_cout   (in_cout),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_res   (out_res),
      .out_flags (out_flags),
      .occupancy (occupancy)
`ifdef ALU_STICKY_OVF_EN
      ,
      .clr_sticky(clr_sticky),
      .sticky_v  (sticky_v),
      .ovf_count (ovf_count)
`endif
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // {cout, res} of a + b, or a - b done as a + ~b + 1
   function automatic logic [32:0] arith(input logic sub, input logic [31:0] a, input logic [31:0] b);
      if (sub) return {1'b0, a} + {1'b0, ~b} + 33'd1;
      else     return {1'b0, a} + {1'b0, b};
   endfunction

   // Flags from the mathematical result: V is set when the exact signed value does not fit 32 bits
   function automatic logic [3:0] ref_flags(input logic sub, input logic [31:0] a, input logic [31:0] b);
      logic [32:0] full;
      longint      sa, sb, ex;
      logic        v;
      full = arith(sub, a, b);
      sa   = longint'($signed(a));
      sb   = longint'($signed(b));
      ex   = sub ? sa - sb : sa + sb;
      v    = (ex > 64'sd2147483647) || (ex < -64'sd2147483648);
      return {full[31], full[31:0] == 32'd0, full[32], v};
   endfunction

   task automatic drive(input logic v, input logic sub, input logic [31:0] a, input logic [31:0] b);
      logic [32:0] full;
      full     = arith(sub, a, b);
      in_valid = v;
      in_sub   = sub;
      in_a_msb = a[31];
      in_b_msb = b[31];
      in_res   = full[31:0];
      in_cout  = full[32];
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 4))
         0:       return 32'h0000_0000;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   typedef struct {
      logic        sub;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [3:0]  flags;
   } vec_t;

   vec_t tbl[7];
   logic [35:0] q[$];

   initial begin
      tbl[0] = '{1'b1, 32'd5,         32'd3,         32'h0000_0002, 4'b0010};
      tbl[1] = '{1'b1, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 4'b0011};
      tbl[2] = '{1'b0, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 4'b0110};
      tbl[3] = '{1'b0, 32'd1,         32'd1,         32'h0000_0002, 4'b0000};
      tbl[4] = '{1'b0, 32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 4'b1001};
      tbl[5] = '{1'b1, 32'd0,         32'd1,         32'hFFFF_FFFF, 4'b1000};
      tbl[6] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 4'b0110};

      rst_n     = 1'b0;
      out_ready = 1'b0;
      drive(1'b0, 1'b0, 32'd0, 32'd0);
`ifdef ALU_STICKY_OVF_EN
      clr_sticky = 1'b0;
`endif
      @(negedge clk);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_occupancy", occupancy, 0);
      chk("reset_in_ready",  in_ready,  1);
      chk("reset_out_res",   out_res,   0);
      chk("reset_out_flags", out_flags, 0);
`ifdef ALU_STICKY_OVF_EN
      chk("reset_sticky_v",  sticky_v,  0);
      chk("reset_ovf_count", ovf_count, 0);
`endif
      rst_n = 1'b1;
      @(negedge clk);

      // Directed vectors, one at a time through an empty buffer
      out_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, tbl[i].sub, tbl[i].a, tbl[i].b);
         @(negedge clk);
         in_valid = 1'b0;
         chk($sformatf("vec%0d_out_res", i),   out_res,   tbl[i].res);
         chk($sformatf("vec%0d_out_flags", i), out_flags, tbl[i].flags);
         chk($sformatf("vec%0d_occupancy", i), occupancy, 1);
`ifdef ALU_STICKY_OVF_EN
         if (i == 1) begin
            chk("vec1_sticky_v",  sticky_v,  1);
            chk("vec1_ovf_count", ovf_count, 1);
         end
`endif
         @(negedge clk);
         chk($sformatf("vec%0d_drained", i), occupancy, 0);
      end

      // Back-pressure: 7 then 9 held, extra push ignored, then drained in order
      out_ready = 1'b0;
      drive(1'b1, 1'b0, 32'd3, 32'd4);
      @(negedge clk);
      chk("bp_occ1", occupancy, 1);
      drive(1'b1, 1'b0, 32'd4, 32'd5);
      @(negedge clk);
      chk("bp_occ2",      occupancy, 2);
      chk("bp_in_ready0", in_ready,  0);
      chk("bp_head7",     out_res,   7);
      drive(1'b1, 1'b0, 32'd5, 32'd6);
      @(negedge clk);
      chk("bp_full_occ",  occupancy, 2);
      chk("bp_hold7",     out_res,   7);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_second9",   out_res,   9);
      chk("bp_occ_back1", occupancy, 1);
      chk("bp_in_ready1", in_ready,  1);
      @(negedge clk);
      chk("bp_empty_valid", out_valid, 0);
      chk("bp_empty_occ",   occupancy, 0);

      // Simultaneous push and pop while holding one entry
      out_ready = 1'b0;
      drive(1'b1, 1'b0, 32'd3, 32'd4);
      @(negedge clk);
      chk("pp_head7", out_res, 7);
      out_ready = 1'b1;
      drive(1'b1, 1'b0, 32'd4, 32'd5);
      @(negedge clk);
      in_valid = 1'b0;
      chk("pp_occ1",  occupancy, 1);
      chk("pp_res9",  out_res,   9);
      chk("pp_valid", out_valid, 1);
      @(negedge clk);
      chk("pp_drained", occupancy, 0);

      // Asynchronous reset between edges while full
      out_ready = 1'b0;
      drive(1'b1, 1'b0, 32'd3, 32'd4);
      @(negedge clk);
      drive(1'b1, 1'b0, 32'd4, 32'd5);
      @(negedge clk);
      in_valid = 1'b0;
      chk("rst_pre_occ2", occupancy, 2);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_valid", out_valid, 0);
      chk("rst_async_occ",   occupancy, 0);
      chk("rst_async_ready", in_ready,  1);
      #1 rst_n = 1'b1;
      @(negedge clk);
      out_ready = 1'b1;
      drive(1'b1, 1'b0, 32'd10, 32'd11);
      @(negedge clk);
      in_valid = 1'b0;
      chk("rst_after_res", out_res,   21);
      chk("rst_after_occ", occupancy, 1);
      @(negedge clk);

      // Randomized traffic against the scoreboard model
      begin
         logic        acc, rel, clr, v;
         logic [3:0]  f;
         logic [31:0] a, b;
         logic        sub;
         logic        m_sticky;
         logic [15:0] m_cnt;
         m_sticky = 1'b0;
         m_cnt    = 16'd0;
         clr      = 1'b0;
`ifdef ALU_STICKY_OVF_EN
         clr_sticky = 1'b1;
         @(negedge clk);
         clr_sticky = 1'b0;
`endif
         q.delete();
         for (int cyc = 0; cyc < 400; cyc++) begin
            chk("rnd_out_valid", out_valid, q.size() > 0);
            chk("rnd_occupancy", occupancy, q.size());
            chk("rnd_in_ready",  in_ready,  q.size() < 2);
            if (q.size() > 0) begin
               chk("rnd_out_res",   out_res,   q[0][35:4]);
               chk("rnd_out_flags", out_flags, q[0][3:0]);
            end
`ifdef ALU_STICKY_OVF_EN
            chk("rnd_sticky_v",  sticky_v,  m_sticky);
            chk("rnd_ovf_count", ovf_count, m_cnt);
            clr        = ($urandom_range(0, 19) == 0);
            clr_sticky = clr;
`endif
            sub = $urandom_range(0, 1);
            a   = pick();
            b   = ($urandom_range(0, 7) == 0) ? a : pick();
            drive($urandom_range(0, 9) < 7, sub, a, b);
            out_ready = ($urandom_range(0, 9) < 6);
            f   = ref_flags(sub, a, b);
            v   = f[0];
            acc = in_valid && (q.size() < 2);
            rel = (q.size() > 0) && out_ready;
            @(posedge clk);
            if (rel) void'(q.pop_front());
            if (acc) q.push_back({in_res, f});
            if (acc && v) begin
               m_sticky = 1'b1;
               if (clr)                  m_cnt = 16'd1;
               else if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end else if (clr) begin
               m_sticky = 1'b0;
               m_cnt    = 16'd0;
            end
            @(negedge clk);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
